// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU input sequencer.
// Holds the state encoding, the default operand width and the state_led patterns.
package alu_seq_pkg;

    localparam int OPW_DEFAULT = 32;
    localparam int SW_OPND_W   = 17;

    typedef enum logic [2:0] {
        ST_LOAD_A  = 3'd0,
        ST_LOAD_B  = 3'd1,
        ST_LOAD_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SHOW    = 3'd4
    } seq_state_e;

    localparam logic [3:0] LED_LOAD_A  = 4'b0001;
    localparam logic [3:0] LED_LOAD_B  = 4'b0010;
    localparam logic [3:0] LED_LOAD_OP = 4'b0100;
    localparam logic [3:0] LED_SHOW    = 4'b1000;

    // EXEC is a single transient cycle, so it shares the SHOW pattern.
    function automatic logic [3:0] state_led_of(input seq_state_e s);
        logic [3:0] led;
        case (s)
            ST_LOAD_A:  led = LED_LOAD_A;
            ST_LOAD_B:  led = LED_LOAD_B;
            ST_LOAD_OP: led = LED_LOAD_OP;
            ST_EXEC:    led = LED_SHOW;
            ST_SHOW:    led = LED_SHOW;
            default:    led = LED_LOAD_A;
        endcase
        return led;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer, debouncer and press detector for one active-low pushbutton.
// A press after reset is only reported once the key has been seen released for a full window.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             stable_r;
    logic             prev_r;
    logic             armed_r;
    logic [CNT_W-1:0] cnt_r;
    logic             press_r;

    // Synchronize, debounce and register the falling-edge event.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r  <= 1'b0;
            sync2_r  <= 1'b0;
            stable_r <= 1'b1;
            prev_r   <= 1'b1;
            armed_r  <= 1'b0;
            cnt_r    <= '0;
            press_r  <= 1'b0;
        end else begin
            sync1_r <= key_raw;
            sync2_r <= sync1_r;
            prev_r  <= stable_r;
            press_r <= armed_r & prev_r & ~stable_r;
            // Until armed, only a full window of released samples counts.
            if (!armed_r) begin
                if (sync2_r) begin
                    if (cnt_r == CNT_LAST) begin
                        armed_r <= 1'b1;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end else begin
                    cnt_r <= '0;
                end
            end else if (sync2_r != stable_r) begin
                if (cnt_r == CNT_LAST) begin
                    stable_r <= sync2_r;
                    cnt_r    <= '0;
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end else begin
                cnt_r <= '0;
            end
        end
    end

    assign press = press_r;

endmodule

// File: rtl/alu_input_seq.sv
// Collects two operands and an opcode from switches, one KEY[0] press per step; KEY[3] clears.
// Define ALU_SEQ_SIGN_EXT_EN to sign-extend SW[16] into the upper operand bits.
module alu_input_seq
    import alu_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int OPW             = OPW_DEFAULT
) (
    input  logic           CLOCK_50,
    input  logic           RST,
    input  logic [3:0]     KEY,
    input  logic [17:0]    SW,
    output logic [OPW-1:0] op1,
    output logic [OPW-1:0] op2,
    output logic [3:0]     opcode,
    output logic           exec_pulse,
    output logic [3:0]     state_led
);

    logic [3:0] press_s;

    for (genvar i = 0; i < 4; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key_debounce (
            .clk    (CLOCK_50),
            .rst    (RST),
            .key_raw(KEY[i]),
            .press  (press_s[i])
        );
    end

    // KEY[1]/KEY[2] are debounced for symmetry but carry no function.
    logic unused_s;
    assign unused_s = ^{SW[17], press_s[2:1]};

    function automatic logic [OPW-1:0] extend(input logic [SW_OPND_W-1:0] v);
`ifdef ALU_SEQ_SIGN_EXT_EN
        return {{(OPW - SW_OPND_W){v[SW_OPND_W-1]}}, v};
`else
        return {{(OPW - SW_OPND_W){1'b0}}, v};
`endif
    endfunction

    seq_state_e     state_r, state_s;
    logic [OPW-1:0] op1_r, op1_s;
    logic [OPW-1:0] op2_r, op2_s;
    logic [3:0]     opcode_r, opcode_s;
    logic           exec_r, exec_s;
    logic [3:0]     led_r, led_s;

    // Next-state and next-output decode; clear outranks every other event.
    always_comb begin
        state_s  = state_r;
        op1_s    = op1_r;
        op2_s    = op2_r;
        opcode_s = opcode_r;
        if (press_s[3]) begin
            state_s  = ST_LOAD_A;
            op1_s    = '0;
            op2_s    = '0;
            opcode_s = 4'd0;
        end else begin
            case (state_r)
                ST_LOAD_A: begin
                    if (press_s[0]) begin
                        op1_s   = extend(SW[SW_OPND_W-1:0]);
                        state_s = ST_LOAD_B;
                    end else begin
                        state_s = ST_LOAD_A;
                    end
                end
                ST_LOAD_B: begin
                    if (press_s[0]) begin
                        op2_s   = extend(SW[SW_OPND_W-1:0]);
                        state_s = ST_LOAD_OP;
                    end else begin
                        state_s = ST_LOAD_B;
                    end
                end
                ST_LOAD_OP: begin
                    if (press_s[0]) begin
                        opcode_s = SW[3:0];
                        state_s  = ST_EXEC;
                    end else begin
                        state_s = ST_LOAD_OP;
                    end
                end
                ST_EXEC: state_s = ST_SHOW;
                ST_SHOW: begin
                    if (press_s[0]) begin
                        state_s = ST_LOAD_A;
                    end else begin
                        state_s = ST_SHOW;
                    end
                end
                default: state_s = ST_LOAD_A;
            endcase
        end
        exec_s = (state_s == ST_EXEC);
        led_s  = state_led_of(state_s);
    end

    // State and registered outputs.
    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            state_r  <= ST_LOAD_A;
            op1_r    <= '0;
            op2_r    <= '0;
            opcode_r <= 4'd0;
            exec_r   <= 1'b0;
            led_r    <= LED_LOAD_A;
        end else begin
            state_r  <= state_s;
            op1_r    <= op1_s;
            op2_r    <= op2_s;
            opcode_r <= opcode_s;
            exec_r   <= exec_s;
            led_r    <= led_s;
        end
    end

    assign op1        = op1_r;
    assign op2        = op2_r;
    assign opcode     = opcode_r;
    assign exec_pulse = exec_r;
    assign state_led  = led_r;

endmodule

// File: doc/alu_input_seq.md
ALU_INPUT_SEQ -- requirements
Module: alu_input_seq

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, number of consecutive stable samples before a key level is accepted.
REQ-002 Parameter OPW, default 32, operand width.
REQ-003 CLOCK_50  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 KEY  input  4  raw pushbuttons, active-low, asynchronous to CLOCK_50.
REQ-006 SW  input  18  SW[16:0] operand value (SW[16] is the sign bit), SW[3:0] opcode value.
REQ-007 op1  output  OPW  latched operand A to ALU.
REQ-008 op2  output  OPW  latched operand B to ALU.
REQ-009 opcode  output  4  latched ALU opcode.
REQ-010 exec_pulse  output  1  one-cycle strobe marking a new operand/opcode set.
REQ-011 state_led  output  4  one-hot current state (LOAD_A, LOAD_B, LOAD_OP, SHOW).

Function
REQ-012 Each KEY bit SHALL pass a two-flop synchronizer, then a debouncer accepting a new level only after DEBOUNCE_CYCLES identical consecutive synchronized samples.
REQ-013 A press event SHALL be a one-cycle pulse on the debounced high-to-low transition; release produces no event; holding a key produces exactly one event.
REQ-014 Event latency SHALL be 2 sync cycles + DEBOUNCE_CYCLES + 1 cycle from a stable KEY edge.
REQ-015 FSM states: LOAD_A, LOAD_B, LOAD_OP, EXEC, SHOW.
REQ-016 LOAD_A + KEY[0] event: op1 <= extend(SW[16:0]), go LOAD_B.
REQ-017 LOAD_B + KEY[0] event: op2 <= extend(SW[16:0]), go LOAD_OP.
REQ-018 LOAD_OP + KEY[0] event: opcode <= SW[3:0], go EXEC.
REQ-019 EXEC SHALL last exactly one cycle, assert exec_pulse, then go SHOW unconditionally.
REQ-020 SHOW + KEY[0] event: go LOAD_A with op1, op2, opcode retained (outputs stable until overwritten).
REQ-021 KEY[3] event in any state: op1, op2, opcode <= 0, go LOAD_A, no exec_pulse.
REQ-022 KEY[3] and KEY[0] events in the same cycle: KEY[3] wins; KEY[0] event discarded.
REQ-023 KEY[1], KEY[2] events SHALL be ignored in all states.
REQ-024 KEY[0] event arriving during EXEC SHALL be discarded (not queued).
REQ-025 state_led SHALL show LOAD_A pattern during LOAD_A, etc.; EXEC displays the SHOW pattern.
REQ-026 Outputs SHALL change only in the cycle after the accepting event; SW changes at other times have no effect.

Reset
REQ-027 RST high at a rising edge: state LOAD_A, op1 = op2 = 0, opcode = 0, exec_pulse = 0, state_led = 4'b0001.
REQ-028 Reset SHALL clear debouncer counters and set accepted key levels to released (high); a key held through reset produces no event until released and pressed again.
REQ-029 Reset mid-sequence (any state) SHALL discard partial loads.

Configuration
REQ-030 Macro ALU_SEQ_SIGN_EXT_EN defined: extend() replicates SW[16] into bits OPW-1:17.
REQ-031 Macro undefined: extend() zero-fills bits OPW-1:17.

Structure
REQ-032 Package alu_seq_pkg SHALL hold the state enum, OPW default, and the state_led encoding constants.
REQ-033 Synchronizer plus debouncer plus edge detect SHALL be sub-module key_debounce, instanced four times.

Verification (DEBOUNCE_CYCLES = 4)
REQ-034 Full sequence: SW=0x00005 press KEY0, SW=0x00003 press KEY0, SW=0x0 press KEY0 -> op1=5, op2=3, opcode=0, one exec_pulse, state SHOW.
REQ-035 Bounce: KEY[0] toggles low/high every 2 cycles for 20 cycles then held low -> exactly one event, after the 4-cycle stable window.
REQ-036 Sign extension: SW=0x1FFFF loaded as op1 -> 0xFFFFFFFF with ALU_SEQ_SIGN_EXT_EN, 0x0001FFFF without.
REQ-037 Clear priority: in LOAD_OP, KEY[3] and KEY[0] pressed simultaneously -> op1=op2=opcode=0, state LOAD_A, no exec_pulse.
REQ-038 Reset mid-operation: RST asserted in LOAD_B with op1=7 -> next cycle op1=0, state_led=4'b0001; KEY[0] held across reset yields no event until re-pressed.
